primitive_assembler: RTL

- Consumer end of the geometry stage's vertex stream.
- Takes BEGIN / VERTEX / END commands carrying transformed 4x16 fixed-point (1.8.7) vertices and colors.
- Groups vertices into points, lines or triangles according to the primitive type latched at BEGIN.
- Hands each complete primitive to the rasterizer over a valid/ready handshake.

---
 rtl/primitive_assembler_pkg.sv | 36 +++
 rtl/primitive_assembler_if.sv | 33 +++
 rtl/primitive_assembler_prim_out_reg.sv | 70 +++++++
 rtl/primitive_assembler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/primitive_assembler_pkg.sv
// Shared definitions for the primitive assembler: command and primitive codes,
// vector geometry and the FSM state encoding.
package primitive_assembler_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int VEC_WIDTH  = 64;
    localparam int CNT_WIDTH  = 16;

    localparam logic [15:0] FIXED_POINT_1 = 16'h0080;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_BEGIN  = 2'd1,
        CMD_VERTEX = 2'd2,
        CMD_END    = 2'd3
    } cmd_e;

    typedef enum logic [3:0] {
        PRIM_POINTS    = 4'd0,
        PRIM_LINES     = 4'd1,
        PRIM_TRIANGLES = 4'd2,
        PRIM_LINESTRIP = 4'd3,
        PRIM_TRISTRIP  = 4'd4
    } prim_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    function automatic logic is_valid_prim(input logic [3:0] t);
        return (t <= 4'd4);
    endfunction

endpackage

// File: rtl/primitive_assembler_if.sv
// Command stream from the geometry stage and primitive stream to the rasterizer.
// slave = assembler view, master = surrounding pipeline view.
interface primitive_assembler_if #(
    parameter int VEC_WIDTH = 64,
    parameter int CNT_WIDTH = 16
);
    logic                 I_Valid;
    logic                 O_Ready;
    logic [1:0]           I_Cmd;
    logic [3:0]           I_Type;
    logic [VEC_WIDTH-1:0] I_Vertex;
    logic [VEC_WIDTH-1:0] I_Color;

    logic                 O_Valid;
    logic                 I_Ready;
    logic [1:0]           O_NumVerts;
    logic [VEC_WIDTH-1:0] O_V0, O_V1, O_V2;
    logic [VEC_WIDTH-1:0] O_C0, O_C1, O_C2;
    logic [CNT_WIDTH-1:0] O_PrimCount;
    logic                 O_Error;

    modport slave (
        input  I_Valid, I_Cmd, I_Type, I_Vertex, I_Color, I_Ready,
        output O_Ready, O_Valid, O_NumVerts, O_V0, O_V1, O_V2,
               O_C0, O_C1, O_C2, O_PrimCount, O_Error
    );

    modport master (
        output I_Valid, I_Cmd, I_Type, I_Vertex, I_Color, I_Ready,
        input  O_Ready, O_Valid, O_NumVerts, O_V0, O_V1, O_V2,
               O_C0, O_C1, O_C2, O_PrimCount, O_Error
    );
endinterface

// File: rtl/primitive_assembler_prim_out_reg.sv
// Output holding register: loads a finished primitive, holds it while the
// rasterizer stalls, and counts completed handshakes.
module prim_out_reg #(
    parameter int VEC_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_lock,
    input  logic                 i_ready,
    input  logic                 i_load,
    input  logic [1:0]           i_num,
    input  logic [VEC_WIDTH-1:0] i_v0, i_v1, i_v2,
    input  logic [VEC_WIDTH-1:0] i_c0, i_c1, i_c2,
    output logic                 o_valid,
    output logic [1:0]           o_num,
    output logic [VEC_WIDTH-1:0] o_v0, o_v1, o_v2,
    output logic [VEC_WIDTH-1:0] o_c0, o_c1, o_c2,
    output logic [CNT_WIDTH-1:0] o_count
);
    logic                 r_valid;
    logic [1:0]           r_num;
    logic [VEC_WIDTH-1:0] r_v0, r_v1, r_v2, r_c0, r_c1, r_c2;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_handshake;

    assign w_handshake = i_lock && r_valid && i_ready;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_num   <= 2'd0;
            r_v0    <= '0;
            r_v1    <= '0;
            r_v2    <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_count <= '0;
        end else begin
            if (w_handshake) begin
                r_count <= r_count + 1'b1;
            end
            // A new load on the draining edge keeps valid high with no bubble.
            if (i_load) begin
                r_valid <= 1'b1;
                r_num   <= i_num;
                r_v0    <= i_v0;
                r_v1    <= i_v1;
                r_v2    <= i_v2;
                r_c0    <= i_c0;
                r_c1    <= i_c1;
                r_c2    <= i_c2;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_num   = r_num;
    assign o_v0    = r_v0;
    assign o_v1    = r_v1;
    assign o_v2    = r_v2;
    assign o_c0    = r_c0;
    assign o_c1    = r_c1;
    assign o_c2    = r_c2;
    assign o_count = r_count;

endmodule

// File: rtl/primitive_assembler.sv
// Groups BEGIN/VERTEX/END vertex commands into points, lines and triangles
// and hands each finished primitive to the rasterizer.
module primitive_assembler
    import primitive_assembler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int VEC_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET_N,
    input  logic                  I_LOCK,
    primitive_assembler_if.slave  bus
);
    typedef logic [VEC_WIDTH/DATA_WIDTH-1:0][DATA_WIDTH-1:0] vec_t;

    state_e     r_state, w_state_next;
    prim_e      r_type,  w_type_next;
    logic [1:0] r_k,     w_k_next;
    logic       r_parity, w_parity_next;
    logic       r_error, w_error_next;
    vec_t       r_w0v, r_w0c, r_w1v, r_w1c;
    vec_t       w_w0v_next, w_w0c_next, w_w1v_next, w_w1c_next;

    logic       w_accept;
    logic       w_load;
    logic [1:0] w_num;
    vec_t       w_v0, w_v1, w_v2, w_c0, w_c1, w_c2;
    vec_t       w_vin, w_cin;

    assign bus.O_Ready = I_LOCK && (!bus.O_Valid || bus.I_Ready);
    assign w_accept    = bus.I_Valid && bus.O_Ready;
    assign w_vin       = bus.I_Vertex;
    assign w_cin       = bus.I_Color;
    assign bus.O_Error = r_error;

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state  <= ST_IDLE;
            r_type   <= PRIM_POINTS;
            r_k      <= 2'd0;
            r_parity <= 1'b0;
            r_error  <= 1'b0;
            r_w0v    <= '0;
            r_w0c    <= '0;
            r_w1v    <= '0;
            r_w1c    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_type   <= w_type_next;
            r_k      <= w_k_next;
            r_parity <= w_parity_next;
            r_error  <= w_error_next;
            r_w0v    <= w_w0v_next;
            r_w0c    <= w_w0c_next;
            r_w1v    <= w_w1v_next;
            r_w1c    <= w_w1c_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_type_next   = r_type;
        w_k_next      = r_k;
        w_parity_next = r_parity;
        w_error_next  = r_error;
        w_w0v_next    = r_w0v;
        w_w0c_next    = r_w0c;
        w_w1v_next    = r_w1v;
        w_w1c_next    = r_w1c;
        w_load        = 1'b0;
        w_num         = 2'd0;
        w_v0 = '0; w_v1 = '0; w_v2 = '0;
        w_c0 = '0; w_c1 = '0; w_c2 = '0;

        if (w_accept) begin
            case (cmd_e'(bus.I_Cmd))
                CMD_BEGIN: begin
                    // BEGIN inside an open primitive acts as an implicit END.
                    if (r_state != ST_IDLE) w_error_next = 1'b1;
                    w_k_next      = 2'd0;
                    w_parity_next = 1'b0;
                    if (is_valid_prim(bus.I_Type)) begin
                        w_state_next = ST_COLLECT;
                        w_type_next  = prim_e'(bus.I_Type);
                    end else begin
                        w_state_next = ST_DISCARD;
                        w_error_next = 1'b1;
                    end
                end
                CMD_END: begin
                    if (r_state == ST_IDLE) w_error_next = 1'b1;
                    else                    w_state_next = ST_IDLE;
                end
                CMD_VERTEX: begin
                    if (r_state == ST_IDLE) begin
                        w_error_next = 1'b1;
                    end else if (r_state == ST_COLLECT) begin
                        case (r_type)
                            PRIM_POINTS: begin
                                w_load = 1'b1; w_num = 2'd1;
                                w_v0 = w_vin; w_c0 = w_cin;
                            end
                            PRIM_LINES: begin
                                if (r_k == 2'd1) begin
                                    w_load = 1'b1; w_num = 2'd2;
                                    w_v0 = r_w0v; w_c0 = r_w0c;
                                    w_v1 = w_vin; w_c1 = w_cin;
                                    w_k_next = 2'd0;
                                end else begin
                                    w_w0v_next = w_vin; w_w0c_next = w_cin;
                                    w_k_next = 2'd1;
                                end
                            end
                            PRIM_TRIANGLES: begin
                                if (r_k == 2'd2) begin
                                    w_load = 1'b1; w_num = 2'd3;
                                    w_v0 = r_w0v; w_c0 = r_w0c;
                                    w_v1 = r_w1v; w_c1 = r_w1c;
                                    w_v2 = w_vin; w_c2 = w_cin;
                                    w_k_next = 2'd0;
                                end else if (r_k == 2'd0) begin
                                    w_w0v_next = w_vin; w_w0c_next = w_cin;
                                    w_k_next = 2'd1;
                                end else begin
                                    w_w1v_next = w_vin; w_w1c_next = w_cin;
                                    w_k_next = 2'd2;
                                end
                            end
                            PRIM_LINESTRIP: begin
                                if (r_k != 2'd0) begin
                                    w_load = 1'b1; w_num = 2'd2;
                                    w_v0 = r_w1v; w_c0 = r_w1c;
                                    w_v1 = w_vin; w_c1 = w_cin;
                                end
                                w_w1v_next = w_vin; w_w1c_next = w_cin;
                                if (r_k != 2'd2) w_k_next = r_k + 2'd1;
                            end
                            PRIM_TRISTRIP: begin
                                // Odd triangles swap the first two vertices to keep winding.
                                if (r_k == 2'd2) begin
                                    w_load = 1'b1; w_num = 2'd3;
                                    w_v0 = r_parity ? r_w1v : r_w0v;
                                    w_c0 = r_parity ? r_w1c : r_w0c;
                                    w_v1 = r_parity ? r_w0v : r_w1v;
                                    w_c1 = r_parity ? r_w0c : r_w1c;
                                    w_v2 = w_vin; w_c2 = w_cin;
                                    w_parity_next = !r_parity;
                                end
                                w_w0v_next = r_w1v; w_w0c_next = r_w1c;
                                w_w1v_next = w_vin; w_w1c_next = w_cin;
                                if (r_k != 2'd2) w_k_next = r_k + 2'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    prim_out_reg #(
        .VEC_WIDTH (VEC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out (
        .i_clk   (I_CLOCK),
        .i_rst_n (I_RESET_N),
        .i_lock  (I_LOCK),
        .i_ready (bus.I_Ready),
        .i_load  (w_load),
        .i_num   (w_num),
        .i_v0    (w_v0),
        .i_v1    (w_v1),
        .i_v2    (w_v2),
        .i_c0    (w_c0),
        .i_c1    (w_c1),
        .i_c2    (w_c2),
        .o_valid (bus.O_Valid),
        .o_num   (bus.O_NumVerts),
        .o_v0    (bus.O_V0),
        .o_v1    (bus.O_V1),
        .o_v2    (bus.O_V2),
        .o_c0    (bus.O_C0),
        .o_c1    (bus.O_C1),
        .o_c2    (bus.O_C2),
        .o_count (bus.O_PrimCount)
    );

endmodule
